// File: rtl/bist_session_scheduler.sv
// Purpose : sequences a multi-session BIST run (load seed/poly, step patterns, settle, check signature).
// Latency : load rises the cycle after a start edge is sampled; bist_end follows N_SESSIONS*(N_PATTERNS+SETTLE_CYC+2) cycles later.
// Backpressure: none; the datapath is slaved to load/run/capture, and start edges outside IDLE/DONE are dropped.
//
// Ports:
//   clk, rst          rising-edge clock, asynchronous active-high reset
//   start             run request, rising edge only
//   sig_in, exp_sig   MISR signature and expected signature for the current session
//   session           current session index
//   load/run/capture  datapath controls: seed load strobe, pattern step enable, compare strobe
//   busy, bist_end    sequence active / sequence complete (level)
//   pass, fail_mask   overall result and per-session mismatch bits, meaningful while bist_end
module bist_session_scheduler #(
    parameter int N_SESSIONS = 4,
    parameter int N_PATTERNS = 1000,
    parameter int CNT_W      = 10,
    parameter int SIG_W      = 16,
    parameter int SETTLE_CYC = 2,
    localparam int SESS_W    = (N_SESSIONS > 1) ? $clog2(N_SESSIONS) : 1,
    localparam int SET_W     = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [SIG_W-1:0]      sig_in,
    input  logic [SIG_W-1:0]      exp_sig,
    output logic [SESS_W-1:0]     session,
    output logic                  load,
    output logic                  run,
    output logic                  capture,
    output logic                  busy,
    output logic                  bist_end,
    output logic                  pass,
    output logic [N_SESSIONS-1:0] fail_mask
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_RUN    = 3'd2,
        S_SETTLE = 3'd3,
        S_CHECK  = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    localparam logic [CNT_W-1:0]  PAT_LAST  = CNT_W'(N_PATTERNS - 1);
    localparam logic [SET_W-1:0]  SET_LAST  = SET_W'(SETTLE_CYC - 1);
    localparam logic [SESS_W-1:0] SESS_LAST = SESS_W'(N_SESSIONS - 1);

    state_t                  state, state_nxt;
    logic                    start_q;
    logic                    start_edge;
    logic [CNT_W-1:0]        cnt, cnt_nxt;
    logic [SET_W-1:0]        scnt, scnt_nxt;
    logic [SESS_W-1:0]       sess_nxt;
    logic [N_SESSIONS-1:0]   mask_nxt;

    assign start_edge = start & ~start_q;

    // State and bookkeeping registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            start_q   <= 1'b0;
            cnt       <= '0;
            scnt      <= '0;
            session   <= '0;
            fail_mask <= '0;
        end else begin
            state     <= state_nxt;
            start_q   <= start;
            cnt       <= cnt_nxt;
            scnt      <= scnt_nxt;
            session   <= sess_nxt;
            fail_mask <= mask_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        scnt_nxt  = scnt;
        sess_nxt  = session;
        mask_nxt  = fail_mask;
        case (state)
            S_IDLE, S_DONE: begin
                if (start_edge) begin
                    state_nxt = S_LOAD;
                    sess_nxt  = '0;
                    mask_nxt  = '0;
                end
            end
            S_LOAD: begin
                state_nxt = S_RUN;
                cnt_nxt   = '0;
            end
            S_RUN: begin
                // Terminal count is compared explicitly so the counter never relies on wrap.
                if (cnt == PAT_LAST) begin
                    state_nxt = S_SETTLE;
                    scnt_nxt  = '0;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            S_SETTLE: begin
                if (scnt == SET_LAST) begin
                    state_nxt = S_CHECK;
                end else begin
                    scnt_nxt = scnt + 1'b1;
                end
            end
            S_CHECK: begin
                if (sig_in != exp_sig) begin
                    mask_nxt[session] = 1'b1;
                end
                if (session == SESS_LAST) begin
                    state_nxt = S_DONE;
                end else begin
                    state_nxt = S_LOAD;
                    sess_nxt  = session + 1'b1;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Outputs are decoded from the next state and registered, so they track the
    // state register exactly and carry no combinational path from the inputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            load     <= 1'b0;
            run      <= 1'b0;
            capture  <= 1'b0;
            busy     <= 1'b0;
            bist_end <= 1'b0;
            pass     <= 1'b0;
        end else begin
            load     <= (state_nxt == S_LOAD);
            run      <= (state_nxt == S_RUN);
            capture  <= (state_nxt == S_CHECK);
            busy     <= (state_nxt == S_LOAD) || (state_nxt == S_RUN) ||
                        (state_nxt == S_SETTLE) || (state_nxt == S_CHECK);
            bist_end <= (state_nxt == S_DONE);
            pass     <= (state_nxt == S_DONE) && ~|mask_nxt;
        end
    end

endmodule

// File: tb/tb_bist_session_scheduler.sv
// Purpose : scoreboard bench for bist_session_scheduler (2 sessions, 8 patterns, settle 2).
// Latency : expects load at k, k+12, capture at k+11, k+23, bist_end at k+24 after a start edge at k.
// Backpressure: not applicable; the monitor pops one expected event per observed strobe.
module tb_bist_session_scheduler;

    localparam int NS = 2;
    localparam int NP = 8;
    localparam int SC = 2;
    localparam int PER = 1 + NP + SC + 1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [15:0] sig_in;
    logic [15:0] exp_sig;
    logic        session;
    logic        load, run, capture, busy, bist_end, pass;
    logic [1:0]  fail_mask;
    logic        bad_s1 = 1'b0;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct {
        int       kind;   // 0 load, 1 capture, 2 done
        int       cyc;
        int       sess;
        logic [1:0] mask;
        logic     pass;
    } ev_t;

    ev_t sb[$];

    bist_session_scheduler #(
        .N_SESSIONS(NS), .N_PATTERNS(NP), .CNT_W(3), .SIG_W(16), .SETTLE_CYC(SC)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .sig_in(sig_in), .exp_sig(exp_sig),
        .session(session), .load(load), .run(run), .capture(capture), .busy(busy),
        .bist_end(bist_end), .pass(pass), .fail_mask(fail_mask)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Signature ROM model: per-session expected value; datapath corrupts session 1 when asked.
    assign exp_sig = session ? 16'h1234 : 16'hA5C3;
    assign sig_in  = (bad_s1 && session) ? (exp_sig ^ 16'h00FF) : exp_sig;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops the next expected event whenever the DUT presents a strobe.
    int   run_cnt = 0;
    logic end_q = 1'b0;

    task automatic pop_and_check(input int kind);
        ev_t e;
        if (sb.size() == 0) begin
            chk("unexpected_event", 32'(kind), 32'hFFFF_FFFF);
        end else begin
            e = sb.pop_front();
            chk("event_kind", 32'(kind), 32'(e.kind));
            chk("event_cycle", 32'(cyc), 32'(e.cyc));
            if (kind == 2) begin
                chk("done_fail_mask", {30'd0, fail_mask}, {30'd0, e.mask});
                chk("done_pass", {31'd0, pass}, {31'd0, e.pass});
                chk("done_busy", {31'd0, busy}, 32'd0);
            end else begin
                chk("event_session", {31'd0, session}, 32'(e.sess));
            end
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            run_cnt = 0;
            end_q   = 1'b0;
        end else begin
            if (run) run_cnt++;
            if (load) begin
                pop_and_check(0);
                run_cnt = 0;
            end
            if (capture) begin
                pop_and_check(1);
                chk("run_cycles", 32'(run_cnt), 32'(NP));
            end
            if (bist_end && !end_q) pop_and_check(2);
            end_q = bist_end;
        end
    end

    task automatic push_seq(input int k, input logic [1:0] mask);
        for (int s = 0; s < NS; s++) begin
            sb.push_back('{kind: 0, cyc: k + PER * s, sess: s, mask: 2'b00, pass: 1'b0});
            sb.push_back('{kind: 1, cyc: k + PER * s + PER - 1, sess: s, mask: 2'b00, pass: 1'b0});
        end
        sb.push_back('{kind: 2, cyc: k + PER * NS, sess: 0, mask: mask, pass: (mask == 2'b00)});
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while (!bist_end && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk(name, {31'd0, bist_end}, 32'd1);
    endtask

    // One start pulse; the next posedge is the sampling edge k.
    task automatic run_seq(input logic [1:0] mask);
        @(negedge clk);
        start = 1'b1;
        push_seq(cyc + 1, mask);
        @(negedge clk);
        start = 1'b0;
        wait_done("done_reached");
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_session"}, {31'd0, session}, 32'd0);
        chk({tag, "_load"}, {31'd0, load}, 32'd0);
        chk({tag, "_run"}, {31'd0, run}, 32'd0);
        chk({tag, "_capture"}, {31'd0, capture}, 32'd0);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
        chk({tag, "_bist_end"}, {31'd0, bist_end}, 32'd0);
        chk({tag, "_pass"}, {31'd0, pass}, 32'd0);
        chk({tag, "_fail_mask"}, {30'd0, fail_mask}, 32'd0);
    endtask

    initial begin
        int k;
        // 1: reset, then quiet for 20 cycles with start low.
        repeat (3) @(negedge clk);
        check_idle_outputs("in_reset");
        rst = 1'b0;
        repeat (20) @(negedge clk);
        check_idle_outputs("idle");

        // 2: clean run.
        run_seq(2'b00);

        // 3: session 1 mismatches.
        bad_s1 = 1'b1;
        run_seq(2'b10);
        bad_s1 = 1'b0;

        // 4: start held high for 100 cycles yields a single sequence.
        @(negedge clk);
        start = 1'b1;
        push_seq(cyc + 1, 2'b00);
        repeat (100) @(negedge clk);
        chk("held_start_done", {31'd0, bist_end}, 32'd1);
        chk("held_start_busy", {31'd0, busy}, 32'd0);
        start = 1'b0;
        repeat (5) @(negedge clk);
        chk("held_start_still_done", {31'd0, bist_end}, 32'd1);

        // 5: extra pulses while busy, sampled at k+1, k+5, k+10, k+12, k+23.
        @(negedge clk);
        start = 1'b1;
        k = cyc + 1;
        push_seq(k, 2'b00);
        for (int c = k; c < k + 24; c++) begin
            @(negedge clk);
            start = (c + 1 == k + 1) || (c + 1 == k + 5) || (c + 1 == k + 10) ||
                    (c + 1 == k + 12) || (c + 1 == k + 23);
        end
        start = 1'b0;
        wait_done("done_with_noise");

        // 6: reset in the middle of session 1 RUN.
        @(negedge clk);
        start = 1'b1;
        k = cyc + 1;
        push_seq(k, 2'b00);
        @(negedge clk);
        start = 1'b0;
        while (cyc < k + 15) @(negedge clk);
        chk("pre_abort_run", {31'd0, run}, 32'd1);
        chk("pre_abort_session", {31'd0, session}, 32'd1);
        rst = 1'b1;
        sb.delete();
        #1;
        check_idle_outputs("abort");
        @(negedge clk);
        rst = 1'b0;
        repeat (30) @(negedge clk);
        chk("no_end_after_abort", {31'd0, bist_end}, 32'd0);
        run_seq(2'b00);

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
